// File: rtl/unary_operand_tx_pkg.sv
// Shared types and defaults for the unary operand transmitter.
package unary_operand_tx_pkg;

    // Binary operand width on the request interface.
    localparam int OPW = 5;

    // Default maximum unary value, which is also the SEND window length.
    localparam int LEN_DEFAULT = 16;

    // Default result width; must satisfy 2^SW > 2*LEN.
    localparam int SW_DEFAULT = 6;

    // Operation sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Limit an operand to the largest value the unary stream can carry.
    function automatic logic [OPW-1:0] clamp_op(input logic [OPW-1:0] v,
                                                input logic [OPW-1:0] lim);
        logic [OPW-1:0] r;
        if (v > lim) begin
            r = lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/unary_therm_gen.sv
// Thermometer stream generator: turns two latched binary operands into
// ones-first unary bit streams over a LEN-cycle window.
module unary_therm_gen
    import unary_operand_tx_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] a_in,
    input  logic [OPW-1:0] b_in,
    output logic           a_bit,
    output logic           b_bit,
    output logic           send_last
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LEN);

    logic [CW-1:0]  cnt_r;
    logic [OPW-1:0] a_r;
    logic [OPW-1:0] b_r;
    logic           active_r;
    logic           a_bit_r;
    logic           b_bit_r;

    // Latch operands on start, then emit bit k = (k < operand) each cycle;
    // cnt_r holds the index of the bit being prepared for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            a_r      <= {OPW{1'b0}};
            b_r      <= {OPW{1'b0}};
            active_r <= 1'b0;
            a_bit_r  <= 1'b0;
            b_bit_r  <= 1'b0;
        end else if (start) begin
            a_r      <= a_in;
            b_r      <= b_in;
            cnt_r    <= CW'(1);
            active_r <= 1'b1;
            a_bit_r  <= (a_in != {OPW{1'b0}});
            b_bit_r  <= (b_in != {OPW{1'b0}});
        end else if (active_r) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r    <= {CW{1'b0}};
                active_r <= 1'b0;
                a_bit_r  <= 1'b0;
                b_bit_r  <= 1'b0;
            end else begin
                cnt_r    <= cnt_r + CW'(1);
                a_bit_r  <= (32'(cnt_r) < 32'(a_r));
                b_bit_r  <= (32'(cnt_r) < 32'(b_r));
            end
        end else begin
            a_bit_r <= 1'b0;
            b_bit_r <= 1'b0;
        end
    end

    assign a_bit     = a_bit_r;
    assign b_bit     = b_bit_r;
    // High during the final (k = LEN-1) cycle of the window.
    assign send_last = active_r && (cnt_r == LAST_CNT);

endmodule

// File: rtl/unary_operand_tx.sv
// Unary operand transmitter: accepts a binary operand pair, streams it to a
// unary adder as thermometer code, then reads back and counts the result.
module unary_operand_tx
    import unary_operand_tx_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT,
    parameter int SW  = SW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [OPW-1:0] op_a,
    input  logic [OPW-1:0] op_b,
    output logic           A,
    output logic           B,
    output logic           en,
    output logic           read_or_write,
    input  logic           dout,
    input  logic           C,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [SW-1:0]  res_sum,
    output logic           res_carry,
    output logic           res_clamp
);

    localparam int DCW = $clog2(2 * LEN + 2);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * LEN + 1);
    localparam logic [OPW-1:0] LEN_OP     = OPW'(LEN);
    localparam logic [SW-1:0]  SUM_MAX    = {SW{1'b1}};

    state_t         state_r;
    state_t         state_next_s;
    logic           flush_r;
    logic [DCW-1:0] dcnt_r;
    logic [SW-1:0]  sum_r;
    logic           carry_r;
    logic           clamp_r;
    logic           en_r;
    logic           rw_r;
    logic           res_valid_r;
    logic           op_ready_r;
    logic           hs_s;
    logic           send_last_s;
    logic           carry_win_s;
    logic           count_s;
    logic [OPW-1:0] a_cl_s;
    logic [OPW-1:0] b_cl_s;

    assign hs_s   = op_valid && op_ready_r;
    assign a_cl_s = clamp_op(op_a, LEN_OP);
    assign b_cl_s = clamp_op(op_b, LEN_OP);

    // The first DRAIN cycle is adder latency; counting starts on the second.
    assign count_s = (state_r == ST_DRAIN) && (dcnt_r != {DCW{1'b0}});

    // Carry is observable from the first SEND cycle up to the first DRAIN cycle.
    assign carry_win_s = (state_r == ST_SEND) || (state_r == ST_FLUSH) ||
                         ((state_r == ST_DRAIN) && (dcnt_r == {DCW{1'b0}}));

    unary_therm_gen #(
        .LEN (LEN)
    ) u_therm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (hs_s),
        .a_in      (a_cl_s),
        .b_in      (b_cl_s),
        .a_bit     (A),
        .b_bit     (B),
        .send_last (send_last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision for the operation sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (send_last_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_FLUSH: begin
                if (flush_r) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                // End on the first sampled zero, or unconditionally at timeout.
                if (count_s && (!dout || (dcnt_r == DRAIN_LAST))) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Cycle counters for the FLUSH and DRAIN phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_r <= 1'b0;
            dcnt_r  <= {DCW{1'b0}};
        end else begin
            if (state_r == ST_FLUSH) begin
                flush_r <= ~flush_r;
            end else begin
                flush_r <= 1'b0;
            end
            if (state_r == ST_DRAIN) begin
                dcnt_r <= dcnt_r + DCW'(1);
            end else begin
                dcnt_r <= {DCW{1'b0}};
            end
        end
    end

    // Result accumulation: saturating ones count, sticky carry, clamp flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= {SW{1'b0}};
            carry_r <= 1'b0;
            clamp_r <= 1'b0;
        end else if (hs_s) begin
            sum_r   <= {SW{1'b0}};
            carry_r <= 1'b0;
            clamp_r <= (op_a > LEN_OP) || (op_b > LEN_OP);
        end else begin
            if (count_s && dout && (sum_r != SUM_MAX)) begin
                sum_r <= sum_r + SW'(1);
            end else begin
                sum_r <= sum_r;
            end
            if (carry_win_s && C) begin
                carry_r <= 1'b1;
            end else begin
                carry_r <= carry_r;
            end
            clamp_r <= clamp_r;
        end
    end

    // Registered control outputs, aligned with the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r        <= 1'b0;
            rw_r        <= 1'b0;
            res_valid_r <= 1'b0;
            op_ready_r  <= 1'b0;
        end else begin
            en_r        <= (state_next_s == ST_SEND) || (state_next_s == ST_FLUSH) ||
                           (state_next_s == ST_DRAIN);
            rw_r        <= (state_next_s == ST_DRAIN);
            res_valid_r <= (state_next_s == ST_DONE);
            op_ready_r  <= (state_next_s == ST_IDLE);
        end
    end

    assign en            = en_r;
    assign read_or_write = rw_r;
    assign res_valid     = res_valid_r;
    assign op_ready      = op_ready_r;
    assign res_sum       = sum_r;
    assign res_carry     = carry_r;
    assign res_clamp     = clamp_r;

endmodule
